// File: rtl/uart_tx_mmio.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_tx_mmio : bus-mapped 8N1 UART transmitter with a TX FIFO and status reg
// Revision 1.0
// ---------------------------------------------------------------------------
module uart_tx_mmio #(
   parameter logic [31:0] BASE_ADDR    = 32'h0080_0000,
   parameter int          CLKS_PER_BIT = 16,
   parameter int          FIFO_DEPTH   = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [3:0]  byteenable,
   input  logic        w_en,
   input  logic        r_en,
   output logic [31:0] rdata,
   output logic        uart_txd,
   output logic        tx_busy
);

   localparam int              AW        = $clog2(FIFO_DEPTH);
   localparam int              CW        = AW + 1;
   localparam int              BW        = $clog2(CLKS_PER_BIT);
   localparam logic [BW-1:0]   BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0]   DEPTH_C   = CW'(FIFO_DEPTH);
   localparam logic [31:0]     STAT_ADDR = BASE_ADDR + 32'd4;

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

   state_e          state_q, state_d;
   logic [BW-1:0]   baud_q, baud_d;
   logic [2:0]      bit_q, bit_d;
   logic [7:0]      shift_q, shift_d;
   logic            txd_q, txd_d;
   logic            busy_q, busy_d;
   logic            ovf_q, ovf_d;
   logic [31:0]     rdata_q, rdata_d;
   logic [AW-1:0]   wptr_q, rptr_q;
   logic [CW-1:0]   count_q, count_d;
   logic [7:0]      mem_q [FIFO_DEPTH];

   logic is_data, is_stat, push_req, push, pop, full, empty, baud_last;
   logic unused_bits;

   assign is_data   = (addr == BASE_ADDR);
   assign is_stat   = (addr == STAT_ADDR);
   assign push_req  = w_en & is_data & byteenable[0];
   assign full      = (count_q == DEPTH_C);
   assign empty     = (count_q == '0);
   assign baud_last = (baud_q == BAUD_LAST);
   // A pop on the same edge frees the slot, so a push into a full FIFO survives.
   assign push      = push_req & (~full | pop);
   assign unused_bits = ^{wdata[31:8], byteenable[3:1]};

   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      pop     = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (!empty) begin
               pop     = 1'b1;
               shift_d = mem_q[rptr_q];
               baud_d  = '0;
               state_d = S_START;
            end
         end
         S_START: begin
            if (baud_last) begin
               baud_d  = '0;
               bit_d   = 3'd0;
               state_d = S_DATA;
            end else begin
               baud_d = baud_q + BW'(1);
            end
         end
         S_DATA: begin
            if (baud_last) begin
               baud_d  = '0;
               shift_d = {1'b0, shift_q[7:1]};
               if (bit_q == 3'd7) state_d = S_STOP;
               else               bit_d   = bit_q + 3'd1;
            end else begin
               baud_d = baud_q + BW'(1);
            end
         end
         S_STOP: begin
            if (baud_last) begin
               baud_d = '0;
               if (!empty) begin
                  pop     = 1'b1;
                  shift_d = mem_q[rptr_q];
                  state_d = S_START;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               baud_d = baud_q + BW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      ovf_d = ovf_q;
      if (push_req && !push)                 ovf_d = 1'b1;
      if (w_en && is_stat && wdata[2])       ovf_d = 1'b0;

      // Output bit is derived from the upcoming state so the pin is registered.
      case (state_d)
         S_START: txd_d = 1'b0;
         S_DATA:  txd_d = shift_d[0];
         default: txd_d = 1'b1;
      endcase
      busy_d = (count_d != '0) | (state_d != S_IDLE);

      rdata_d = rdata_q;
      if (r_en) rdata_d = is_stat ? {28'b0, ovf_q, busy_q, empty, full} : 32'd0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         txd_q   <= 1'b1;
         busy_q  <= 1'b0;
         ovf_q   <= 1'b0;
         rdata_q <= '0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         txd_q   <= txd_d;
         busy_q  <= busy_d;
         ovf_q   <= ovf_d;
         rdata_q <= rdata_d;
         count_q <= count_d;
         if (push) wptr_q <= wptr_q + AW'(1);
         if (pop)  rptr_q <= rptr_q + AW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wptr_q] <= wdata[7:0];
   end

   assign rdata    = rdata_q;
   assign uart_txd = txd_q;
   assign tx_busy  = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_mmio.sv
`default_nettype none
// tb_uart_tx_mmio : randomized self-checking bench with a serial decoder and
// a queue-based reference of the bytes the UART should emit.
module tb_uart_tx_mmio;

   localparam logic [31:0] BASE  = 32'h0080_0000;
   localparam logic [31:0] STAT  = BASE + 32'd4;
   localparam int          CPB   = 16;
   localparam int          DEPTH = 8;
   localparam int          FRAME = 10 * CPB;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] addr, wdata, rdata;
   logic [3:0]  byteenable;
   logic        w_en, r_en, uart_txd, tx_busy;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   logic [7:0] rxq[$];
   int         starts[$];
   int         mon_err = 0;

   uart_tx_mmio #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .byteenable(byteenable),
      .w_en(w_en), .r_en(r_en), .rdata(rdata), .uart_txd(uart_txd), .tx_busy(tx_busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Serial decoder: samples mid-bit on falling clock edges.
   initial begin : monitor
      logic [7:0] b;
      int         s;
      bit         okf;
      forever begin
         @(negedge clk);
         if (uart_txd === 1'b0) begin
            s   = cyc;
            okf = 1'b1;
            b   = 8'h00;
            repeat (CPB / 2) @(negedge clk);
            if (uart_txd !== 1'b0) okf = 1'b0;
            for (int i = 0; i < 8; i++) begin
               repeat (CPB) @(negedge clk);
               b[i] = uart_txd;
            end
            repeat (CPB) @(negedge clk);
            if (uart_txd !== 1'b1) okf = 1'b0;
            if (okf) begin
               rxq.push_back(b);
               starts.push_back(s);
            end else begin
               mon_err++;
            end
         end
      end
   end

   initial begin : watchdog
      #900000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog expired");
   end

   task automatic bus_idle();
      w_en = 1'b0; r_en = 1'b0; addr = 32'd0; wdata = 32'd0; byteenable = 4'd0;
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
      addr = a; wdata = d; byteenable = be; w_en = 1'b1;
      @(posedge clk); @(negedge clk);
      bus_idle();
   endtask

   task automatic read_reg(input logic [31:0] a, output logic [31:0] v);
      addr = a; r_en = 1'b1;
      @(posedge clk); @(negedge clk);
      v = rdata;
      bus_idle();
   endtask

   task automatic clear_mon();
      rxq.delete(); starts.delete(); mon_err = 0;
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      while (tx_busy !== 1'b0 && n < budget) begin @(negedge clk); n++; end
      checks++;
      if (tx_busy !== 1'b0) begin
         failures++; $display("FAIL drain_timeout: tx_busy=%b required 0 after %0d cycles", tx_busy, budget);
      end
      repeat (4) @(negedge clk);
   endtask

   task automatic test_reset();
      logic [31:0] v;
      bus_idle(); rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++; if (uart_txd !== 1'b1) begin failures++; $display("FAIL reset_txd: got %b required 1", uart_txd); end
      checks++; if (tx_busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b required 0", tx_busy); end
      checks++; if (rdata !== 32'd0) begin failures++; $display("FAIL reset_rdata: got %h required 0", rdata); end
      rst = 1'b0;
      read_reg(STAT, v);
      checks++; if (v !== 32'h2) begin failures++; $display("FAIL reset_stat: got %h required 2", v); end
   endtask

   task automatic test_single();
      int e0;
      clear_mon();
      store(BASE, 32'h0000_0041, 4'b0001);
      e0 = cyc;
      repeat (FRAME) @(negedge clk);
      checks++; if (tx_busy !== 1'b1) begin failures++; $display("FAIL single_busy_end: got %b required 1", tx_busy); end
      @(negedge clk);
      checks++; if (tx_busy !== 1'b0) begin failures++; $display("FAIL single_busy_drop: got %b required 0", tx_busy); end
      checks++;
      if (rxq.size() != 1 || mon_err != 0) begin
         failures++; $display("FAIL single_frames: got %0d frames (%0d bad) required 1", rxq.size(), mon_err);
      end else begin
         checks++; if (rxq[0] !== 8'h41) begin failures++; $display("FAIL single_byte: got %h required 41", rxq[0]); end
         checks++; if (starts[0] - e0 != 1) begin failures++; $display("FAIL single_latency: got %0d required 1", starts[0] - e0); end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] d, v;
      logic [7:0]  exp[$];
      clear_mon();
      for (int i = 0; i < 9; i++) begin
         d = $urandom(); d[7:0] = 8'h30 + 8'(i);
         exp.push_back(d[7:0]);
         store(BASE, d, 4'($urandom()) | 4'b0001);
      end
      wait_idle(10 * FRAME);
      checks++;
      if (rxq.size() != exp.size() || mon_err != 0) begin
         failures++; $display("FAIL b2b_count: got %0d frames (%0d bad) required %0d", rxq.size(), mon_err, exp.size());
      end else begin
         for (int i = 0; i < exp.size(); i++) begin
            checks++; if (rxq[i] !== exp[i]) begin failures++; $display("FAIL b2b_byte%0d: got %h required %h", i, rxq[i], exp[i]); end
            if (i > 0) begin
               checks++;
               if (starts[i] - starts[i-1] != FRAME) begin
                  failures++; $display("FAIL b2b_gap%0d: got %0d cycles required %0d", i, starts[i] - starts[i-1], FRAME);
               end
            end
         end
      end
      read_reg(STAT, v);
      checks++; if (v !== 32'h2) begin failures++; $display("FAIL b2b_stat: got %h required 2", v); end
   endtask

   task automatic test_overflow();
      logic [31:0] v;
      logic [7:0]  sent[$];
      clear_mon();
      for (int i = 0; i < 11; i++) begin
         sent.push_back(8'h30 + 8'(i));
         store(BASE, {24'h0, 8'h30 + 8'(i)}, 4'b0001);
      end
      read_reg(STAT, v);
      checks++; if (v !== 32'hD) begin failures++; $display("FAIL ovf_stat_set: got %h required d", v); end
      store(STAT, $urandom() | 32'h4, 4'hF);
      read_reg(STAT, v);
      checks++; if (v !== 32'h5) begin failures++; $display("FAIL ovf_stat_clr: got %h required 5", v); end
      wait_idle(11 * FRAME);
      // one slot is freed by the immediate pop, so DEPTH+1 bytes get through
      checks++;
      if (rxq.size() != DEPTH + 1 || mon_err != 0) begin
         failures++; $display("FAIL ovf_count: got %0d frames (%0d bad) required %0d", rxq.size(), mon_err, DEPTH + 1);
      end else begin
         for (int i = 0; i <= DEPTH; i++) begin
            checks++; if (rxq[i] !== sent[i]) begin failures++; $display("FAIL ovf_byte%0d: got %h required %h", i, rxq[i], sent[i]); end
         end
      end
      read_reg(STAT, v);
      checks++; if (v !== 32'h2) begin failures++; $display("FAIL ovf_stat_end: got %h required 2", v); end
   endtask

   task automatic test_ignored();
      logic [31:0] v;
      int lows;
      clear_mon();
      store(BASE, $urandom(), 4'($urandom()) & 4'b1110);
      store(BASE + 32'd8, $urandom(), 4'hF);
      read_reg(STAT, v);
      checks++; if (v !== 32'h2) begin failures++; $display("FAIL ign_stat: got %h required 2", v); end
      read_reg(BASE, v);
      checks++; if (v !== 32'h0) begin failures++; $display("FAIL ign_data_read: got %h required 0", v); end
      read_reg(STAT, v);
      read_reg(BASE + 32'd8, v);
      checks++; if (v !== 32'h0) begin failures++; $display("FAIL ign_other_read: got %h required 0", v); end
      read_reg(STAT, v);
      addr = BASE + 32'd8;
      lows = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (uart_txd !== 1'b1 || tx_busy !== 1'b0) lows++;
      end
      bus_idle();
      checks++; if (rdata !== 32'h2) begin failures++; $display("FAIL ign_rdata_hold: got %h required 2", rdata); end
      checks++; if (lows != 0) begin failures++; $display("FAIL ign_line_idle: got %0d active cycles required 0", lows); end
   endtask

   task automatic test_reset_midframe();
      logic [31:0] v;
      int n, off, lows;
      clear_mon();
      for (int i = 0; i < 3; i++) store(BASE, $urandom(), 4'b0001);
      n = 0;
      while (starts.size() == 0 && rxq.size() == 0 && uart_txd !== 1'b0 && n < 100) begin @(negedge clk); n++; end
      checks++;
      if (uart_txd !== 1'b0) begin
         failures++; $display("FAIL rstmid_start: got txd=%b required 0", uart_txd);
      end else begin
         off = $urandom_range(66, 78);
         repeat (off) @(negedge clk);
         rst = 1'b1;
         @(posedge clk); @(negedge clk);
         checks++; if (uart_txd !== 1'b1) begin failures++; $display("FAIL rstmid_txd: got %b required 1", uart_txd); end
         checks++; if (tx_busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy: got %b required 0", tx_busy); end
         rst = 1'b0;
         read_reg(STAT, v);
         checks++; if (v !== 32'h2) begin failures++; $display("FAIL rstmid_stat: got %h required 2", v); end
         lows = 0;
         for (int i = 0; i < 3 * FRAME; i++) begin
            @(negedge clk);
            if (uart_txd !== 1'b1 || tx_busy !== 1'b0) lows++;
         end
         checks++; if (lows != 0) begin failures++; $display("FAIL rstmid_quiet: got %0d active cycles required 0", lows); end
      end
      clear_mon();
   endtask

   task automatic test_poll();
      logic [31:0] v;
      logic [7:0]  sent[$];
      int i, iter;
      bit ovf_seen, full_seen;
      clear_mon();
      for (int k = 0; k < 20; k++) sent.push_back(8'($urandom()));
      i = 0; iter = 0; ovf_seen = 0; full_seen = 0;
      while (i < 20 && iter < 20000) begin
         read_reg(STAT, v);
         if (v[3]) ovf_seen = 1;
         if (v[0]) full_seen = 1;
         if (!v[0]) begin
            store(BASE, {$urandom()} & 32'hFFFF_FF00 | {24'h0, sent[i]}, 4'b0001);
            i++;
         end
         iter++;
      end
      checks++; if (i != 20) begin failures++; $display("FAIL poll_timeout: got %0d stores required 20", i); end
      checks++; if (full_seen != 1'b1) begin failures++; $display("FAIL poll_full_seen: got %0d required 1", full_seen); end
      read_reg(BASE, v);
      read_reg(STAT, v);
      checks++; if (v[3:2] !== 2'b01) begin failures++; $display("FAIL poll_rd_latency: got %h required ovf=0 busy=1", v); end
      wait_idle(22 * FRAME);
      checks++; if (ovf_seen) begin failures++; $display("FAIL poll_overflow: got 1 required 0"); end
      checks++;
      if (rxq.size() != 20 || mon_err != 0) begin
         failures++; $display("FAIL poll_count: got %0d frames (%0d bad) required 20", rxq.size(), mon_err);
      end else begin
         for (int k = 0; k < 20; k++) begin
            checks++; if (rxq[k] !== sent[k]) begin failures++; $display("FAIL poll_byte%0d: got %h required %h", k, rxq[k], sent[k]); end
         end
      end
      read_reg(STAT, v);
      checks++; if (v !== 32'h2) begin failures++; $display("FAIL poll_stat_end: got %h required 2", v); end
   endtask

   initial begin
      rst = 1'b1;
      bus_idle();
      @(negedge clk);
      test_reset();
      test_single();
      test_back_to_back();
      test_overflow();
      test_ignored();
      test_reset_midframe();
      test_poll();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
